// File: rtl/hd44780_resp.sv
// HD44780 LCD controller responder: decodes host bus writes, models busy timing and DDRAM.
// Optional violation tracking is compiled in with `define HD44780_RESP_VIOL_EN.
module hd44780_resp #(
   parameter int unsigned CMD_CYCLES   = 10,
   parameter int unsigned CLEAR_CYCLES = 410
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       e,
   input  logic       rs,
   input  logic [7:0] db,
   output logic       busy,
   output logic [6:0] ac,
   output logic       cg_sel,
   output logic       disp_on,
   output logic       cur_on,
   output logic       blink_on,
   output logic       inc,
   output logic       shift,
   output logic       dl,
   output logic       nl,
   output logic       font,
   output logic [5:0] disp_ofs,
   input  logic [6:0] raddr,
   output logic [7:0] rdata,
   output logic       viol,
   output logic [7:0] viol_cnt
);

   localparam int unsigned TMAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] timer;
   logic          e_s1, e_s2, e_prev;
   logic          rs_s1, rs_s2;
   logic [7:0]    db_s1, db_s2;
   logic [4:0]    arm_sr;
   logic          fall, exec, clr_home;
   logic          clr_active;
   logic [6:0]    clr_idx;
   logic [7:0]    ddram [80];
   logic          mem_we;
   logic [6:0]    mem_waddr;
   logic [7:0]    mem_wdata;

   function automatic logic dd_ok(input logic [6:0] a);
      return a < 7'h68;
   endfunction

   function automatic logic [6:0] dd_idx(input logic [6:0] a);
      return (a < 7'h40) ? a : a - 7'd24;
   endfunction

   // Out-of-range addresses snap to the start of the following valid range.
   function automatic logic [6:0] step_dd(input logic [6:0] a, input logic up, input logic two);
      logic [6:0] r;
      if (!two) begin
         if (a > 7'h4F)   r = 7'h00;
         else if (up)     r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
         else             r = (a == 7'h00) ? 7'h4F : a - 7'd1;
      end else if (a >= 7'h28 && a < 7'h40) begin
         r = 7'h40;
      end else if (a >= 7'h68) begin
         r = 7'h00;
      end else if (up) begin
         r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      end else begin
         r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
      end
      return r;
   endfunction

   function automatic logic [6:0] step_ac(input logic [6:0] a, input logic up,
                                          input logic cg, input logic two);
      logic [5:0] c;
      c = up ? a[5:0] + 6'd1 : a[5:0] - 6'd1;
      return cg ? {1'b0, c} : step_dd(a, up, two);
   endfunction

   function automatic logic [5:0] step_ofs(input logic [5:0] o, input logic up);
      if (up) return (o == 6'd39) ? 6'd0 : o + 6'd1;
      return (o == 6'd0) ? 6'd39 : o - 6'd1;
   endfunction

   // arm_sr masks edges from pin transitions during the first two cycles after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_s1 <= 1'b0; e_s2 <= 1'b0; e_prev <= 1'b0;
         rs_s1 <= 1'b0; rs_s2 <= 1'b0;
         db_s1 <= '0; db_s2 <= '0;
         arm_sr <= '0;
      end else begin
         e_s1 <= e; e_s2 <= e_s1; e_prev <= e_s2;
         rs_s1 <= rs; rs_s2 <= rs_s1;
         db_s1 <= db; db_s2 <= db_s1;
         arm_sr <= {arm_sr[3:0], 1'b1};
      end
   end

   assign fall     = e_prev & ~e_s2 & arm_sr[4];
   assign exec     = fall && (state == IDLE);
   assign clr_home = !rs_s2 && (db_s2[7:2] == 6'd0) && (db_s2[1:0] != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (exec) state_nx = BUSY;
         BUSY: if (timer == TW'(1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == BUSY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
         ac <= '0; cg_sel <= 1'b0;
         disp_on <= 1'b0; cur_on <= 1'b0; blink_on <= 1'b0;
         inc <= 1'b1; shift <= 1'b0;
         dl <= 1'b1; nl <= 1'b0; font <= 1'b0;
         disp_ofs <= '0;
         clr_active <= 1'b0; clr_idx <= '0;
      end else begin
         if (state == BUSY) timer <= timer - TW'(1);
         if (clr_active) begin
            if (clr_idx == 7'd79) clr_active <= 1'b0;
            else                  clr_idx <= clr_idx + 7'd1;
         end
         if (exec) begin
            timer <= clr_home ? TW'(CLEAR_CYCLES) : TW'(CMD_CYCLES);
            if (rs_s2) begin
               ac <= step_ac(ac, inc, cg_sel, nl);
               if (!cg_sel && shift) disp_ofs <= step_ofs(disp_ofs, inc);
            end else begin
               casez (db_s2)
                  8'b1???????: begin ac <= db_s2[6:0]; cg_sel <= 1'b0; end
                  8'b01??????: begin ac <= {1'b0, db_s2[5:0]}; cg_sel <= 1'b1; end
                  8'b001?????: begin dl <= db_s2[4]; nl <= db_s2[3]; font <= db_s2[2]; end
                  8'b0001????: begin
                     if (db_s2[3]) disp_ofs <= step_ofs(disp_ofs, db_s2[2]);
                     else          ac <= step_ac(ac, db_s2[2], cg_sel, nl);
                  end
                  8'b00001???: begin
                     disp_on <= db_s2[2]; cur_on <= db_s2[1]; blink_on <= db_s2[0];
                  end
                  8'b000001??: begin inc <= db_s2[1]; shift <= db_s2[0]; end
                  8'b0000001?: begin ac <= '0; disp_ofs <= '0; cg_sel <= 1'b0; end
                  8'b00000001: begin
                     ac <= '0; disp_ofs <= '0; cg_sel <= 1'b0; inc <= 1'b1;
                     clr_active <= 1'b1; clr_idx <= '0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (clr_active) begin
         mem_we    = 1'b1;
         mem_waddr = clr_idx;
         mem_wdata = 8'h20;
      end else if (exec && rs_s2 && !cg_sel && dd_ok(ac)) begin
         mem_we    = 1'b1;
         mem_waddr = dd_idx(ac);
         mem_wdata = db_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) ddram[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               rdata <= '0;
      else if (dd_ok(raddr))  rdata <= ddram[dd_idx(raddr)];
      else                    rdata <= '0;
   end

`ifdef HD44780_RESP_VIOL_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         viol     <= 1'b0;
         viol_cnt <= '0;
      end else if (fall && state == BUSY) begin
         viol <= 1'b1;
         if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
      end
   end
`else
   assign viol     = 1'b0;
   assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_hd44780_resp.sv
// Randomized scoreboard bench for hd44780_resp against a behavioural LCD controller model.
module tb_hd44780_resp;

   localparam int unsigned CMD = 10;
   localparam int unsigned CLR = 410;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       e = 1'b0, rs = 1'b0;
   logic [7:0] db = '0;
   logic       busy, cg_sel, disp_on, cur_on, blink_on, inc, shift, dl, nl, font, viol;
   logic [6:0] ac, raddr = '0;
   logic [5:0] disp_ofs;
   logic [7:0] rdata, viol_cnt;

   hd44780_resp #(.CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR)) dut (
      .clk(clk), .rst(rst), .e(e), .rs(rs), .db(db), .busy(busy), .ac(ac),
      .cg_sel(cg_sel), .disp_on(disp_on), .cur_on(cur_on), .blink_on(blink_on),
      .inc(inc), .shift(shift), .dl(dl), .nl(nl), .font(font), .disp_ofs(disp_ofs),
      .raddr(raddr), .rdata(rdata), .viol(viol), .viol_cnt(viol_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      int unsigned blen;
      logic [6:0]  ac;
      logic        cg;
      logic [7:0]  flags;
      logic [5:0]  ofs;
   } exp_t;

   exp_t exp_q[$];
   int unsigned n_checks = 0, n_err = 0;

   // Reference model state
   logic [6:0] m_ac;
   logic       m_cg, m_disp, m_cur, m_blink, m_inc, m_shift, m_dl, m_nl, m_font;
   int         m_ofs;
   logic [7:0] m_mem [80];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_flags();
      return {m_disp, m_cur, m_blink, m_inc, m_shift, m_dl, m_nl, m_font};
   endfunction

   function automatic void m_reset();
      m_ac = 0; m_cg = 0; m_disp = 0; m_cur = 0; m_blink = 0;
      m_inc = 1; m_shift = 0; m_dl = 1; m_nl = 0; m_font = 0; m_ofs = 0;
   endfunction

   // Address stepping via position along the linear sequence of valid addresses.
   function automatic logic [6:0] m_step(input logic [6:0] a, input bit up);
      int p;
      if (m_cg) return 7'((int'(a[5:0]) + (up ? 1 : 63)) % 64);
      if (m_nl) begin
         if (a < 7'h28) p = int'(a);
         else if (a >= 7'h40 && a < 7'h68) p = int'(a) - 24;
         else return (a < 7'h40) ? 7'h40 : 7'h00;
         p = up ? (p + 1) % 80 : (p + 79) % 80;
         return (p < 40) ? 7'(p) : 7'(p + 24);
      end
      if (a >= 7'h50) return 7'h00;
      return 7'(up ? (int'(a) + 1) % 80 : (int'(a) + 79) % 80);
   endfunction

   function automatic int unsigned m_exec(input bit r, input logic [7:0] d);
      if (r) begin
         if (!m_cg) begin
            if (m_ac < 7'h68) m_mem[(m_ac < 7'h40) ? int'(m_ac) : int'(m_ac) - 24] = d;
            if (m_shift) m_ofs = (m_ofs + (m_inc ? 1 : 39)) % 40;
         end
         m_ac = m_step(m_ac, m_inc);
         return CMD;
      end
      if (d[7])      begin m_ac = d[6:0]; m_cg = 0; end
      else if (d[6]) begin m_ac = {1'b0, d[5:0]}; m_cg = 1; end
      else if (d[5]) begin m_dl = d[4]; m_nl = d[3]; m_font = d[2]; end
      else if (d[4]) begin
         if (d[3]) m_ofs = (m_ofs + (d[2] ? 1 : 39)) % 40;
         else      m_ac = m_step(m_ac, d[2]);
      end
      else if (d[3]) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
      else if (d[2]) begin m_inc = d[1]; m_shift = d[0]; end
      else if (d[1]) begin m_ac = 0; m_ofs = 0; m_cg = 0; return CLR; end
      else if (d[0]) begin
         m_ac = 0; m_ofs = 0; m_cg = 0; m_inc = 1;
         for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
         return CLR;
      end
      return CMD;
   endfunction

   // Monitor: each busy->idle transition completes one command.
   int unsigned mon_len = 0;
   logic        mon_prev = 1'b0;
   always @(negedge clk) begin
      exp_t x;
      if (!rst) begin
         mon_len  = 0;
         mon_prev = 1'b0;
      end else begin
         if (busy) mon_len++;
         else if (mon_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               x = exp_q.pop_front();
               chk("busy_len", mon_len, x.blen);
               chk("ac", 32'(ac), 32'(x.ac));
               chk("cg_sel", 32'(cg_sel), 32'(x.cg));
               chk("flags", 32'({disp_on, cur_on, blink_on, inc, shift, dl, nl, font}), 32'(x.flags));
               chk("disp_ofs", 32'(disp_ofs), 32'(x.ofs));
            end
            mon_len = 0;
         end
         mon_prev = busy;
      end
   end

   task automatic pulse(input bit r, input logic [7:0] d);
      @(negedge clk);
      rs = r; db = d; e = 1'b1;
      repeat (2) @(negedge clk);
      e = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         chk("completion_timeout", 32'd1, 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic send(input bit r, input logic [7:0] d);
      exp_t x;
      x.blen = m_exec(r, d);
      x.ac = m_ac; x.cg = m_cg; x.flags = m_flags(); x.ofs = 6'(m_ofs);
      exp_q.push_back(x);
      pulse(r, d);
      wait_done();
   endtask

   task automatic rd(input logic [6:0] a, input logic [7:0] exp);
      @(negedge clk);
      raddr = a;
      @(negedge clk);
      chk("rdata", 32'(rdata), 32'(exp));
   endtask

   task automatic sweep();
      for (int a = 0; a < 128; a++)
         rd(7'(a), (a < 'h68) ? m_mem[(a < 'h40) ? a : a - 24] : 8'h00);
   endtask

   task automatic chk_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ac", 32'(ac), 32'd0);
      chk("rst_cg", 32'(cg_sel), 32'd0);
      chk("rst_flags", 32'({disp_on, cur_on, blink_on, inc, shift, dl, nl, font}), 32'h14);
      chk("rst_ofs", 32'(disp_ofs), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_viol", 32'(viol), 32'd0);
      chk("rst_viol_cnt", 32'(viol_cnt), 32'd0);
   endtask

   initial begin
      int k, n;
      bit seen;
      logic [7:0] d;
      m_reset();
      for (int i = 0; i < 80; i++) m_mem[i] = 8'h20;
      repeat (3) @(negedge clk);
      #1 chk_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Function set, display control
      send(0, 8'h38);
      send(0, 8'h0E);
      chk("nl", 32'(nl), 32'd1);
      chk("dl", 32'(dl), 32'd1);
      chk("disp_ctrl", 32'({disp_on, cur_on, blink_on}), 32'b110);

      // Clear
      send(0, 8'h01);
      rd(7'h00, 8'h20); rd(7'h27, 8'h20); rd(7'h40, 8'h20); rd(7'h67, 8'h20);
      chk("clr_ac", 32'(ac), 32'd0);
      chk("clr_inc", 32'(inc), 32'd1);

      // Two-line wrap on write
      send(0, 8'hA7);
      send(1, 8'h41);
      rd(7'h27, 8'h41);
      chk("wrap_ac", 32'(ac), 32'h40);

      // Entry mode with shift, then one-line decrement wrap
      send(0, 8'h07);
      send(1, 8'h61); send(1, 8'h62); send(1, 8'h63);
      chk("shift_ofs", 32'(disp_ofs), 32'd3);
      send(0, 8'h30);
      send(0, 8'h80);
      send(0, 8'h10);
      chk("dec_wrap_ac", 32'(ac), 32'h4F);

      // Command while busy
      begin
         exp_t x;
         x.blen = m_exec(0, 8'h0C);
         x.ac = m_ac; x.cg = m_cg; x.flags = m_flags(); x.ofs = 6'(m_ofs);
         exp_q.push_back(x);
      end
      pulse(0, 8'h0C);
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      chk("busy_seen", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      rs = 1'b0; db = 8'h01; e = 1'b1;
      @(negedge clk);
      e = 1'b0;
      wait_done();
`ifdef HD44780_RESP_VIOL_EN
      chk("viol", 32'(viol), 32'd1);
      chk("viol_cnt", 32'(viol_cnt), 32'd1);
`else
      chk("viol", 32'(viol), 32'd0);
      chk("viol_cnt", 32'(viol_cnt), 32'd0);
`endif
      rst = 1'b0;
      #1 chk_reset();
      m_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset mid-clear, then edge right after release
      pulse(0, 8'h01);
      repeat (50) @(negedge clk);
      e = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("busy_abort", 32'(busy), 32'd0);
      chk_reset();
      m_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      e = 1'b0;
      seen = 0;
      repeat (15) begin @(negedge clk); if (busy) seen = 1; end
      chk("early_edge_ignored", 32'(seen), 32'd0);
      send(0, 8'h80);
      send(1, 8'h55);
      rd(7'h00, 8'h55);

      // Re-establish known DDRAM, then randomized traffic
      send(0, 8'h01);
      sweep();
      for (int it = 0; it < 80; it++) begin
         k = int'($urandom_range(0, 19));
         d = 8'($urandom);
         if (k <= 6)        send(1, d);
         else if (k == 7)   send(0, {1'b1, d[6:0]});
         else if (k == 8)   send(0, {2'b01, d[5:0]});
         else if (k == 9)   send(0, {3'b001, d[4:0]});
         else if (k == 10)  send(0, {4'b0001, d[3:0]});
         else if (k == 11)  send(0, {5'b00001, d[2:0]});
         else if (k == 12)  send(0, {6'b000001, d[1:0]});
         else if (k == 13)  send(0, {7'b0000001, d[0]});
         else if (k == 14)  send(0, ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00);
         else               send(0, {3'b000, d[4:0]});
         if (it % 20 == 19) sweep();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
